// File: rtl/button_debounce_ctrl.sv
// button_debounce_ctrl: synchronise, qualify and edge-detect one mechanical push-button input
module button_debounce_ctrl #(
    parameter int N_MAX    = 5000,
    parameter int N_STABLE = 4
) (
    input  logic clk,
    input  logic rst_a_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);
    localparam int CW = $clog2(N_MAX);
    localparam int SW = $clog2(N_STABLE + 1);
    typedef enum logic [1:0] {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L} state_t;
    state_t        state_q;
    logic          sync_q, btn_s_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] stable_q;
    logic          want, abort, tick, done, new_level;
    assign want      = state_q == S_WAIT_H;
    assign abort     = btn_s_q != want;
    assign tick      = busy && cnt_q == CW'(N_MAX - 1);
    assign done      = tick && stable_q == SW'(N_STABLE - 1);
    assign new_level = abort ? !want : want;
    // Two-flop synchroniser for the raw pin
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync_q  <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync_q  <= btn_in;
            btn_s_q <= sync_q;
        end
    end
    // Qualification FSM with counters and registered level, strobes and busy
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            stable_q  <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state_q)
                S_LOW: if (btn_s_q) begin
                    state_q <= S_WAIT_H;
                    busy    <= 1'b1;
                end
                S_HIGH: if (!btn_s_q) begin
                    state_q <= S_WAIT_L;
                    busy    <= 1'b1;
                end
                S_WAIT_H, S_WAIT_L: begin
                    if (abort || done) begin
                        state_q   <= new_level ? S_HIGH : S_LOW;
                        btn_level <= new_level;
                        btn_rise  <= !abort && want;
                        btn_fall  <= !abort && !want;
                        busy      <= 1'b0;
                        cnt_q     <= '0;
                        stable_q  <= '0;
                    end else begin
                        cnt_q    <= tick ? '0 : cnt_q + CW'(1);
                        stable_q <= stable_q + SW'(tick);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_debounce_ctrl.sv
// tb_button_debounce_ctrl: directed and randomized checks against a run-length debounce model
module tb_button_debounce_ctrl;
    localparam int N_MAX    = 4;
    localparam int N_STABLE = 3;
    localparam int QUAL     = N_STABLE * N_MAX + 1;
    logic clk = 1'b0;
    logic rst_a_n, btn_in;
    logic btn_level, btn_rise, btn_fall, busy;
    int   passed = 0, total = 0;
    int   rise_cnt = 0, fall_cnt = 0;
    logic [1:0] pipe;
    int   run;
    logic m_level, m_rise, m_fall;

    button_debounce_ctrl #(.N_MAX(N_MAX), .N_STABLE(N_STABLE)) dut (
        .clk(clk), .rst_a_n(rst_a_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        pipe = '0; run = 0; m_level = 0; m_rise = 0; m_fall = 0;
    endtask

    task automatic check_model();
        check("level", btn_level, m_level);
        check("rise", btn_rise, m_rise);
        check("fall", btn_fall, m_fall);
        check("busy", busy, run != 0);
    endtask

    // One clock: the accepted level flips once btn_s has differed from it for QUAL consecutive edges
    task automatic step();
        logic bs;
        @(posedge clk);
        if (!rst_a_n) model_reset();
        else begin
            bs = pipe[1];
            pipe = {pipe[0], btn_in};
            m_rise = 0; m_fall = 0;
            run = (bs != m_level) ? run + 1 : 0;
            if (run == QUAL) begin
                m_rise = !m_level; m_fall = m_level; m_level = !m_level; run = 0;
            end
        end
        #1;
        check_model();
        if (btn_rise) rise_cnt++;
        if (btn_fall) fall_cnt++;
    endtask

    task automatic measure(input bit rise, input string tag);
        int k;
        step();
        for (k = 1; k <= 40; k++) begin
            step();
            if (k == 2) check({tag, "_busy_e2"}, busy, 1);
            if (rise ? btn_rise : btn_fall) break;
        end
        check({tag, "_latency"}, k, QUAL + 1);
        step();
        check({tag, "_one_cycle"}, rise ? btn_rise : btn_fall, 0);
    endtask

    initial begin
        int f0, r0;
        rst_a_n = 0; btn_in = 0; model_reset();
        repeat (3) step();
        rst_a_n = 1;
        repeat (5) step();
        // clean press
        f0 = fall_cnt;
        btn_in = 1;
        measure(1, "press");
        check("press_level", btn_level, 1);
        check("press_no_fall", fall_cnt, f0);
        repeat (5) step();
        // asynchronous reset while high with input held
        rst_a_n = 0;
        #1;
        model_reset();
        check("arst_level", btn_level, 0);
        check("arst_busy", busy, 0);
        check("arst_rise", btn_rise, 0);
        check("arst_fall", btn_fall, 0);
        repeat (5) step();
        rst_a_n = 1;
        measure(1, "requal");
        // clean release
        repeat (3) step();
        btn_in = 0;
        measure(0, "release");
        check("release_level", btn_level, 0);
        // bounce: 5-cycle toggles never qualify
        r0 = rise_cnt; f0 = fall_cnt;
        for (int i = 0; i < 60; i++) begin
            btn_in = ((i / 5) % 2) == 0;
            step();
        end
        btn_in = 0;
        repeat (20) step();
        check("bounce_level", btn_level, 0);
        check("bounce_busy", busy, 0);
        check("bounce_strobes", rise_cnt + fall_cnt, r0 + f0);
        // glitch on the completing tick aborts
        r0 = rise_cnt;
        btn_in = 1;
        repeat (12) step();
        btn_in = 0;
        repeat (10) step();
        check("glitch_no_rise", rise_cnt, r0);
        check("glitch_level", btn_level, 0);
        check("glitch_busy", busy, 0);
        // reset in the middle of a qualification
        btn_in = 1;
        repeat (9) step();
        rst_a_n = 0;
        #1;
        model_reset();
        check("midwait_busy", busy, 0);
        check("midwait_level", btn_level, 0);
        repeat (3) step();
        rst_a_n = 1;
        measure(1, "midwait");
        btn_in = 0;
        measure(0, "midwait_rel");
        // randomized segments of random level and length
        for (int s = 0; s < 250; s++) begin
            btn_in = $urandom_range(0, 1);
            repeat ($urandom_range(1, 22)) step();
        end
        btn_in = 0;
        repeat (30) step();
        check("rand_settle_busy", busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
